// File: rtl/lfsr_bus_pkg.sv
// Shared defaults and status-word layout for the LFSR snapshot bus FIFO.
package lfsr_bus_pkg;
    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 4;
    localparam int DEPTH_DEF = 4;

    localparam int OVF_BIT   = 16;
    localparam int FULL_BIT  = 17;
    localparam int EMPTY_BIT = 18;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_DATA = 2'd1,
        RD_STAT = 2'd2
    } rd_kind_e;
endpackage

// File: rtl/lfsr_bus_fifo_snap_fifo.sv
// Snapshot FIFO: storage, wrapping pointers, occupancy and sticky overflow.
module snap_fifo
    import lfsr_bus_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_ovf,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop, drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push
    // alongside it; an empty FIFO rejects the pop but keeps the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            // Overflow set beats a concurrent status-read clear.
            if (drop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end
endmodule

// File: rtl/lfsr_bus_fifo.sv
// Bus front end: address decode, one-cycle registered read data, tri-state drive.
module lfsr_bus_fifo
    import lfsr_bus_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] Faddr,
    input  logic [DW-1:0] Q,
    input  logic          q1_id,
    input  logic          rd,
    output tri   [DW-1:0] d,
    output logic          D_en,
    output logic          ack,
    output logic          err,
    output logic          A_eq_Faddr,
    output logic          A_eq_Stat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    rd_kind_e      rd_kind;
    logic [DW-1:0] head, d_q, stat_word;
    logic [1:0]    vld_pipe;

    assign A_eq_Faddr = (a == Faddr);
    assign A_eq_Stat  = (a == AW'(Faddr + 1'b1));

    always_comb begin
        rd_kind = RD_NONE;
        if (rd && A_eq_Faddr)
            rd_kind = RD_DATA;
        else if (rd && A_eq_Stat)
            rd_kind = RD_STAT;
    end

    always_comb begin
        stat_word            = '0;
        stat_word[CW-1:0]    = count;
        stat_word[OVF_BIT]   = ovf;
        stat_word[FULL_BIT]  = full;
        stat_word[EMPTY_BIT] = empty;
    end

    snap_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (q1_id),
        .pop     (rd_kind == RD_DATA),
        .clr_ovf (rd_kind == RD_STAT),
        .wdata   (Q),
        .rdata   (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf)
    );

    assign vld_pipe[0] = (rd_kind != RD_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[1] <= 1'b0;
            err         <= 1'b0;
            d_q         <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            err         <= (rd_kind == RD_DATA) && empty;
            case (rd_kind)
                RD_DATA: d_q <= empty ? '0 : head;
                RD_STAT: d_q <= stat_word;
                default: d_q <= '0;
            endcase
        end
    end

    assign D_en = vld_pipe[1];
    assign ack  = vld_pipe[1];
    // Reset clears D_en asynchronously, so the bus floats without waiting for an edge.
    assign d    = D_en ? d_q : {DW{1'bz}};
endmodule
